// File: rtl/shift_reg_ctrl_pkg.sv
// Shared state encoding and helpers for the shift_reg_ctrl transaction sequencer.
// bit_reverse is only referenced when SHIFT_REG_CTRL_LSB_FIRST_EN is defined.
package shift_reg_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   // Upper bound on WIDTH for the generic bit-reversal helper.
   localparam int unsigned MaxWidth = 256;

   // A length of 0 or anything beyond the register width means a full-width transfer.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
      return ((len == 0) || (len > width)) ? width : len;
   endfunction

   function automatic logic [MaxWidth-1:0] bit_reverse(input logic [MaxWidth-1:0] d,
                                                       input int unsigned       width);
      logic [MaxWidth-1:0] r;
      r = '0;
      for (int i = 0; i < int'(MaxWidth); i++) begin
         if (i < int'(width)) begin
            r[i] = d[int'(width) - 1 - i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_reg_ctrl_div.sv
// Bit-rate tick generator: while run is high, tick pulses once every CLK_DIV cycles,
// on the last cycle of each bit period. Dropping run restarts the period.
module shift_reg_ctrl_div #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tick
);

   localparam int unsigned    CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

   logic [CntW-1:0] div_cnt_q, div_cnt_d;

   assign tick = run && (div_cnt_q == CntMax);

   always_comb begin
      div_cnt_d = div_cnt_q;
      if (!run || tick) begin
         div_cnt_d = '0;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/shift_reg_ctrl.sv
// Transaction sequencer for one external ShiftReg: load a word, shift len bits at the
// divided bit rate, return the captured word. SHIFT_REG_CTRL_LSB_FIRST_EN selects LSB-first.
module shift_reg_ctrl
   import shift_reg_ctrl_pkg::*;
#(
   parameter  int unsigned WIDTH   = 32,
   parameter  int unsigned CLK_DIV = 1,
   localparam int unsigned LEN_W   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   input  logic [LEN_W-1:0] req_len,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy,
   input  logic             ser_in,
   output logic             ser_out,
   output logic             ser_strobe,
   output logic             sr_srl_prl,
   output logic             sr_srl_in,
   output logic [WIDTH-1:0] sr_prl_in,
   input  logic             sr_srl_out,
   input  logic [WIDTH-1:0] sr_prl_out
);

   state_e           state_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] bit_cnt_q;
   logic             req_ready_q;
   logic             rsp_valid_q;
   logic             busy_q;
   logic             tick;
   logic [WIDTH-1:0] load_word;
   logic [WIDTH-1:0] rsp_word;

`ifdef SHIFT_REG_CTRL_LSB_FIRST_EN
   assign load_word = WIDTH'(bit_reverse(MaxWidth'(req_data), WIDTH));
   assign rsp_word  = WIDTH'(bit_reverse(MaxWidth'(sr_prl_out), WIDTH));
`else
   assign load_word = req_data;
   assign rsp_word  = sr_prl_out;
`endif

   shift_reg_ctrl_div #(
      .CLK_DIV(CLK_DIV)
   ) u_div (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (state_q == StShift),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         len_q       <= '0;
         bit_cnt_q   <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req_valid) begin
                  state_q     <= StShift;
                  len_q       <= LEN_W'(clamp_len(32'(req_len), WIDTH));
                  bit_cnt_q   <= '0;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            StShift: begin
               if (tick) begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q + 1'b1 == len_q) begin
                     state_q     <= StDone;
                     rsp_valid_q <= 1'b1;
                  end
               end
            end
            StDone: begin
               if (rsp_ready) begin
                  state_q     <= StIdle;
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= StIdle;
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // The ShiftReg has no enable: every cycle that is neither a load nor a shift
   // reloads its own parallel output to hold the contents.
   always_comb begin
      sr_srl_prl = 1'b0;
      sr_srl_in  = 1'b0;
      sr_prl_in  = sr_prl_out;
      ser_strobe = 1'b0;
      ser_out    = 1'b0;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               sr_prl_in = load_word;
            end
         end
         StShift: begin
            ser_out = sr_srl_out;
            if (tick) begin
               sr_srl_prl = 1'b1;
               sr_srl_in  = ser_in;
               ser_strobe = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign busy      = busy_q;
   assign rsp_data  = rsp_word;

endmodule
